// File: rtl/count_sequence_checker_pkg.sv
// Shared types and step arithmetic for the count sequence checker.
package count_check_pkg;

  typedef enum logic [1:0] {IDLE, TRACK, FAULT} chk_state_t;

  localparam int unsigned STEP_MAX_W = 32;

  // Expected next count, modulo 2^w; callers truncate to their own width.
  function automatic logic [STEP_MAX_W-1:0] step_exp(
    input logic [STEP_MAX_W-1:0] prev,
    input logic                  fwd,
    input int unsigned           w
  );
    logic [STEP_MAX_W-1:0] mask;
    logic [STEP_MAX_W-1:0] nxt;
    mask = (w >= STEP_MAX_W) ? '1 : ((STEP_MAX_W'(1) << w) - STEP_MAX_W'(1));
    nxt  = fwd ? (prev + STEP_MAX_W'(1)) : (prev - STEP_MAX_W'(1));
    return nxt & mask;
  endfunction

endpackage

// File: rtl/count_sequence_checker_if.sv
// Monitor-side bundle: sampled count, direction, clear and the checker results.
interface count_sequence_checker_if #(
  parameter int unsigned W     = 3,
  parameter int unsigned CNT_W = 8
) ();

  logic [W-1:0]     n;
  logic             forward;
  logic             clear;
  logic [CNT_W-1:0] turns;
  logic [CNT_W-1:0] wraps;
  logic             err;
  logic [W-1:0]     err_seen;
  logic [W-1:0]     err_exp;
  logic             armed;

  modport master (
    output n, forward, clear,
    input  turns, wraps, err, err_seen, err_exp, armed
  );

  modport slave (
    input  n, forward, clear,
    output turns, wraps, err, err_seen, err_exp, armed
  );

endinterface

// File: rtl/count_sequence_checker_sat_counter.sv
// Saturating event counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/count_sequence_checker.sv
// Checks that each sampled count is one step from the previous one in the
// reported direction; counts reversals and wraps, latches the first violation.
module count_sequence_checker
  import count_check_pkg::*;
#(
  parameter int unsigned W     = 3,
  parameter int unsigned CNT_W = 8
) (
  input logic                      clk,
  input logic                      reset,
  count_sequence_checker_if.slave  bus
);

  chk_state_t   state;
  logic [W-1:0] prev_n;
  logic         prev_fwd;
  logic         err_q;
  logic [W-1:0] err_seen_q;
  logic [W-1:0] err_exp_q;
  logic         armed_q;

  logic [W-1:0] exp_n;
  logic         match;
  logic         tracking;
  logic         turn_inc;
  logic         wrap_inc;

  // Direction of the current sample decides the expected step, so a reversal
  // and the first step in the new direction are validated together.
  always_comb begin
    exp_n    = W'(step_exp(STEP_MAX_W'(prev_n), bus.forward, W));
    match    = (bus.n == exp_n);
    tracking = (state == TRACK) && !bus.clear;
    turn_inc = tracking && match && (bus.forward != prev_fwd);
    wrap_inc = tracking && match &&
               (bus.forward ? (prev_n == '1) : (prev_n == '0));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      prev_n     <= '0;
      prev_fwd   <= 1'b0;
      err_q      <= 1'b0;
      err_seen_q <= '0;
      err_exp_q  <= '0;
      armed_q    <= 1'b0;
    end else if (bus.clear) begin
      state      <= IDLE;
      err_q      <= 1'b0;
      err_seen_q <= '0;
      err_exp_q  <= '0;
      armed_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          prev_n   <= bus.n;
          prev_fwd <= bus.forward;
          armed_q  <= 1'b1;
          state    <= TRACK;
        end
        TRACK: begin
          if (match) begin
            prev_n   <= bus.n;
            prev_fwd <= bus.forward;
          end else begin
            err_q      <= 1'b1;
            err_seen_q <= bus.n;
            err_exp_q  <= exp_n;
            state      <= FAULT;
          end
        end
        FAULT: ;
        default: state <= IDLE;
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_turns (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.clear),
    .inc   (turn_inc),
    .q     (bus.turns)
  );

  sat_counter #(.CNT_W(CNT_W)) u_wraps (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.clear),
    .inc   (wrap_inc),
    .q     (bus.wraps)
  );

  assign bus.err      = err_q;
  assign bus.err_seen = err_seen_q;
  assign bus.err_exp  = err_exp_q;
  assign bus.armed    = armed_q;

endmodule

// File: tb/tb_count_sequence_checker.sv
// Scoreboard bench: two checker instances (CNT_W=8 and CNT_W=2) see identical stimulus.
module tb_count_sequence_checker;

  typedef struct packed {
    logic [7:0] turns;
    logic [7:0] wraps;
    logic       err;
    logic [2:0] seen;
    logic [2:0] expv;
    logic       armed;
  } obs_t;

  typedef struct packed {
    int   id;
    obs_t a;
    obs_t b;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   vid = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  count_sequence_checker_if #(.W(3), .CNT_W(8)) if8 ();
  count_sequence_checker_if #(.W(3), .CNT_W(2)) if2 ();

  count_sequence_checker #(.W(3), .CNT_W(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (if8.slave)
  );

  count_sequence_checker #(.W(3), .CNT_W(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (if2.slave)
  );

  function automatic obs_t obs8();
    obs_t o;
    o.turns = if8.turns;
    o.wraps = if8.wraps;
    o.err   = if8.err;
    o.seen  = if8.err_seen;
    o.expv  = if8.err_exp;
    o.armed = if8.armed;
    return o;
  endfunction

  function automatic obs_t obs2();
    obs_t o;
    o.turns = {6'd0, if2.turns};
    o.wraps = {6'd0, if2.wraps};
    o.err   = if2.err;
    o.seen  = if2.err_seen;
    o.expv  = if2.err_exp;
    o.armed = if2.armed;
    return o;
  endfunction

  task automatic check(input string name, input int id, input obs_t act, input obs_t want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s v%0d: got turns=%0d wraps=%0d err=%0b seen=%0d exp=%0d armed=%0b, want turns=%0d wraps=%0d err=%0b seen=%0d exp=%0d armed=%0b",
               name, id, act.turns, act.wraps, act.err, act.seen, act.expv, act.armed,
               want.turns, want.wraps, want.err, want.seen, want.expv, want.armed);
    end
  endtask

  // Monitor: one expected entry per clock edge, compared half a cycle later.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("dut8", e.id, obs8(), e.a);
      check("dut2", e.id, obs2(), e.b);
    end
  end

  task automatic drive(input logic [2:0] nv, input logic f, input logic c);
    if8.n = nv; if8.forward = f; if8.clear = c;
    if2.n = nv; if2.forward = f; if2.clear = c;
  endtask

  function automatic logic [7:0] sat2(input int v);
    return (v > 3) ? 8'd3 : 8'(v);
  endfunction

  // Drive one sample and queue the hand-computed outputs after the next edge.
  task automatic vec_now(input logic [2:0] nv, input logic f, input logic c,
                         input int t, input int w, input logic e,
                         input logic [2:0] s, input logic [2:0] x, input logic a);
    exp_t ex;
    drive(nv, f, c);
    ex.id      = vid;
    ex.a.turns = 8'(t);
    ex.a.wraps = 8'(w);
    ex.a.err   = e;
    ex.a.seen  = s;
    ex.a.expv  = x;
    ex.a.armed = a;
    ex.b       = ex.a;
    ex.b.turns = sat2(t);
    ex.b.wraps = sat2(w);
    sb.push_back(ex);
    vid++;
  endtask

  task automatic vec(input logic [2:0] nv, input logic f, input logic c,
                     input int t, input int w, input logic e,
                     input logic [2:0] s, input logic [2:0] x, input logic a);
    @(negedge clk);
    #1;
    vec_now(nv, f, c, t, w, e, s, x, a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    drive(3'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("reset8", -1, obs8(), '0);
    check("reset2", -1, obs2(), '0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Up count through a wrap
    vec(3'd0, 1'b1, 1'b0, 0, 0, 1'b0, 3'd0, 3'd0, 1'b1);
    for (int i = 1; i < 8; i++) vec(3'(i), 1'b1, 1'b0, 0, 0, 1'b0, 3'd0, 3'd0, 1'b1);
    vec(3'd0, 1'b1, 1'b0, 0, 1, 1'b0, 3'd0, 3'd0, 1'b1);
    vec(3'd1, 1'b1, 1'b0, 0, 1, 1'b0, 3'd0, 3'd0, 1'b1);

    // Reversals
    for (int i = 2; i < 6; i++) vec(3'(i), 1'b1, 1'b0, 0, 1, 1'b0, 3'd0, 3'd0, 1'b1);
    vec(3'd4, 1'b0, 1'b0, 1, 1, 1'b0, 3'd0, 3'd0, 1'b1);
    vec(3'd3, 1'b0, 1'b0, 1, 1, 1'b0, 3'd0, 3'd0, 1'b1);
    vec(3'd4, 1'b1, 1'b0, 2, 1, 1'b0, 3'd0, 3'd0, 1'b1);
    vec(3'd5, 1'b1, 1'b1, 0, 0, 1'b0, 3'd0, 3'd0, 1'b0);

    // Down through a wrap, then a bad step and frozen outputs
    vec(3'd1, 1'b0, 1'b0, 0, 0, 1'b0, 3'd0, 3'd0, 1'b1);
    vec(3'd0, 1'b0, 1'b0, 0, 0, 1'b0, 3'd0, 3'd0, 1'b1);
    vec(3'd7, 1'b0, 1'b0, 0, 1, 1'b0, 3'd0, 3'd0, 1'b1);
    vec(3'd6, 1'b0, 1'b0, 0, 1, 1'b0, 3'd0, 3'd0, 1'b1);
    vec(3'd4, 1'b0, 1'b0, 0, 1, 1'b1, 3'd4, 3'd5, 1'b1);
    for (int i = 0; i < 10; i++)
      vec(3'(5 + i), 1'(i % 2), 1'b0, 0, 1, 1'b1, 3'd4, 3'd5, 1'b1);

    // Clear wins over a bad value in FAULT
    vec(3'd3, 1'b1, 1'b1, 0, 0, 1'b0, 3'd0, 3'd0, 1'b0);

    // Hold is a violation
    vec(3'd0, 1'b1, 1'b0, 0, 0, 1'b0, 3'd0, 3'd0, 1'b1);
    vec(3'd1, 1'b1, 1'b0, 0, 0, 1'b0, 3'd0, 3'd0, 1'b1);
    vec(3'd2, 1'b1, 1'b0, 0, 0, 1'b0, 3'd0, 3'd0, 1'b1);
    vec(3'd2, 1'b1, 1'b0, 0, 0, 1'b1, 3'd2, 3'd3, 1'b1);
    vec(3'd6, 1'b0, 1'b1, 0, 0, 1'b0, 3'd0, 3'd0, 1'b0);

    // Clean tracking after clear, then turn saturation on the 2-bit instance
    vec(3'd5, 1'b0, 1'b0, 0, 0, 1'b0, 3'd0, 3'd0, 1'b1);
    vec(3'd4, 1'b0, 1'b0, 0, 0, 1'b0, 3'd0, 3'd0, 1'b1);
    vec(3'd3, 1'b0, 1'b0, 0, 0, 1'b0, 3'd0, 3'd0, 1'b1);
    vec(3'd4, 1'b1, 1'b0, 1, 0, 1'b0, 3'd0, 3'd0, 1'b1);
    vec(3'd3, 1'b0, 1'b0, 2, 0, 1'b0, 3'd0, 3'd0, 1'b1);
    vec(3'd4, 1'b1, 1'b0, 3, 0, 1'b0, 3'd0, 3'd0, 1'b1);
    vec(3'd3, 1'b0, 1'b0, 4, 0, 1'b0, 3'd0, 3'd0, 1'b1);
    vec(3'd4, 1'b1, 1'b0, 5, 0, 1'b0, 3'd0, 3'd0, 1'b1);
    vec(3'd5, 1'b1, 1'b0, 5, 0, 1'b0, 3'd0, 3'd0, 1'b1);

    // Asynchronous reset between edges; the next sample is only captured
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("areset8", -2, obs8(), '0);
    check("areset2", -2, obs2(), '0);
    #1 reset = 1'b0;
    vec_now(3'd2, 1'b0, 1'b0, 0, 0, 1'b0, 3'd0, 3'd0, 1'b1);
    vec(3'd1, 1'b0, 1'b0, 0, 0, 1'b0, 3'd0, 3'd0, 1'b1);
    vec(3'd0, 1'b0, 1'b0, 0, 0, 1'b0, 3'd0, 3'd0, 1'b1);
    vec(3'd7, 1'b0, 1'b0, 0, 1, 1'b0, 3'd0, 3'd0, 1'b1);
    vec(3'd6, 1'b0, 1'b0, 0, 1, 1'b0, 3'd0, 3'd0, 1'b1);

    repeat (3) @(negedge clk);
    #1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
